// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: word widths, the NOP bubble word, the default
// reset PC, and the {pcadd4, instr} payload carried into IF/ID.
package pipeline_pkg;

    localparam int unsigned INSN_W = 32;
    localparam int unsigned ADDR_W = 32;

    localparam logic [INSN_W-1:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0] pcadd4;
        logic [INSN_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous in-order FIFO with push, pop and clear.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   clear_i        drop all entries (wins over push/pop)
//   push_i/wdata_i write one entry (caller never pushes when full)
//   pop_i          retire head (caller never pops when empty)
//   rdata_o        head entry (undefined when empty)
//   count_o        number of valid entries
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [CNT_W-1:0] cnt_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer and occupancy update.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= ptr_inc(wr_q);
            if (pop_i)  rd_q <= ptr_inc(rd_q);
            cnt_q <= cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // Storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i && !rst) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word requests over req/gnt +
// rvalid, buffers returned words in order and presents {IF_pcadd4,
// IF_instruction} to IF/ID. Redirect flushes the buffer and drops responses
// still in flight for the old stream.
// Optional feature: define FETCH_BYPASS_EN to forward a response straight to
// IF_* when the buffer is empty (one cycle less latency).
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   stall                      IF/ID holding; do not pop
//   redirect, redirect_pc      taken branch/jump and its target
//   imem_req/imem_addr/imem_gnt  request handshake (addr = pc)
//   imem_rvalid/imem_rdata     in-order response
//   IF_pcadd4/IF_instruction   head entry, or 0/NOP when empty
module fetch_unit
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_pcadd4,
    output logic [31:0] IF_instruction
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [CNT_W-1:0]  count, inflight;
    logic [ADDR_W-1:0] tag_head;
    fetch_entry_t      head_e, push_e, out_e;
    logic              fire, retire, take, bypass, out_valid;
    logic              data_push, data_pop;

    // Issue only while buffered + in-flight words stay under the cap.
    assign imem_req  = !rst && !redirect &&
                       ((CNT_W+1)'(count) + (CNT_W+1)'(inflight) < (CNT_W+1)'(DEPTH));
    assign imem_addr = pc_q;
    assign fire      = imem_req && imem_gnt;

    // A response retires the oldest tag; it is kept only when nothing is owed to drop.
    assign retire = imem_rvalid && (inflight != '0);
    assign take   = retire && (drop_q == '0) && !redirect;

    assign push_e.pcadd4 = tag_head + ADDR_W'(4);
    assign push_e.instr  = imem_rdata;

`ifdef FETCH_BYPASS_EN
    assign bypass = (count == '0) && take;
`else
    assign bypass = 1'b0;
`endif

    // Head selection and buffer control.
    always_comb begin
        out_valid = (count != '0);
        out_e     = head_e;
        if (bypass) begin
            out_valid = 1'b1;
            out_e     = push_e;
        end
        data_pop  = !stall && !redirect && (count != '0);
        data_push = take && !(bypass && !stall);
    end

    assign IF_pcadd4      = out_valid ? out_e.pcadd4 : '0;
    assign IF_instruction = out_valid ? out_e.instr  : NOP_WORD;

    // Next pc and drop count; redirect overrides every other event.
    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        if (redirect) begin
            pc_d   = redirect_pc & ~32'h3;
            drop_d = inflight - CNT_W'(retire);
        end else begin
            if (fire) pc_d = pc_q + ADDR_W'(4);
            if (retire && (drop_q != '0)) drop_d = drop_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

    // Tag queue: its occupancy is the in-flight count; never flushed by redirect
    // so dropped responses still retire their tags.
    fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_q (
        .clk     (clk),
        .rst     (rst),
        .clear_i (1'b0),
        .push_i  (fire),
        .wdata_i (pc_q),
        .pop_i   (retire),
        .rdata_o (tag_head),
        .count_o (inflight)
    );

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_data_q (
        .clk     (clk),
        .rst     (rst),
        .clear_i (redirect),
        .push_i  (data_push),
        .wdata_i (push_e),
        .pop_i   (data_pop),
        .rdata_o (head_e),
        .count_o (count)
    );

endmodule
